// File: rtl/rx_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_ctrl_pkg                                                                |
// | Shared types and constants for the RX sample controller.                   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package rx_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TIME = 3'd1,
        S_SAMP0     = 3'd2,
        S_SAMP1     = 3'd3,
        S_ERROR     = 3'd4
    } rx_state_t;

    localparam logic [31:0] c_ERR_ACK          = 32'h1;
    localparam logic [31:0] c_ERR_LATE         = 32'h2;
    localparam logic [31:0] c_ERR_BROKEN_CHAIN = 32'h4;
    localparam logic [31:0] c_ERR_OVERRUN      = 32'h8;

    localparam int c_TDATA_W       = 176;
    localparam int c_OFF_SAMPLE1   = 0;
    localparam int c_OFF_SAMPLE0   = 32;
    localparam int c_OFF_TIME      = 64;
    localparam int c_OFF_SID       = 128;
    localparam int c_OFF_SEQ       = 160;
    localparam int c_BIT_EOP       = 172;
    localparam int c_BIT_EOB       = 173;
    localparam int c_BIT_HAS_TIME  = 174;
    localparam int c_BIT_ODD       = 175;

    localparam logic [7:0] c_REG_CMD     = 8'd0;
    localparam logic [7:0] c_REG_TIME_HI = 8'd1;
    localparam logic [7:0] c_REG_TIME_LO = 8'd2;
    localparam logic [7:0] c_REG_SID     = 8'd3;
    localparam logic [7:0] c_REG_SPP     = 8'd4;

    // Pending slot entry: {cmd[31:0], time[63:0]}
    localparam int c_SLOT_W = 96;

    function automatic logic [63:0] f_err_code(input logic [31:0] code, input logic [11:0] seq);
        return {code, 20'd0, seq};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_cmd_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_cmd_slot                                                                |
// | Single-entry pending command register; commits while full are dropped.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module rx_cmd_slot
    import rx_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_commit,
    input  logic [c_SLOT_W-1:0] i_entry,
    input  logic                i_load,
    input  logic                i_clr,
    output logic                o_full,
    output logic [c_SLOT_W-1:0] o_entry
);
    logic                r_full;
    logic [c_SLOT_W-1:0] r_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (i_load || i_clr) begin
            r_full  <= 1'b0;
        end else if (i_commit && !r_full) begin
            r_full  <= 1'b1;
            r_entry <= i_entry;
        end
    end

    assign o_full  = r_full;
    assign o_entry = r_entry;
endmodule
`default_nettype wire

// File: rtl/time_compare.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | time_compare                                                               |
// | Compares the current time against a trigger time (now / early / late).     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module time_compare (
    input  logic [63:0] i_time_now,
    input  logic [63:0] i_trigger_time,
    output logic        o_now,
    output logic        o_early,
    output logic        o_late
);
    assign o_now   = (i_time_now == i_trigger_time);
    assign o_early = (i_time_now <  i_trigger_time);
    assign o_late  = (i_time_now >  i_trigger_time);
endmodule
`default_nettype wire

// File: rtl/new_rx_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | new_rx_control                                                             |
// | Timed RX sample controller: pairs DSP samples into 176-bit framer lines.   |
// | Optional NEW_RX_CONTROL_STATS_EN adds pkt_count / ovf_count outputs.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module new_rx_control
    import rx_ctrl_pkg::*;
#(
    parameter int BASE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic [63:0]          vita_time,
    input  logic [31:0]          sample,
    input  logic                 strobe,
    output logic                 run,
    output logic [c_TDATA_W-1:0] sample_tdata,
    output logic                 sample_tvalid,
    input  logic                 sample_tready,
    output logic                 error_stb,
    output logic [63:0]          error_code,
    output logic                 busy
`ifdef NEW_RX_CONTROL_STATS_EN
   ,output logic [31:0]          pkt_count,
    output logic [31:0]          ovf_count
`endif
);
    localparam logic [7:0] c_ADDR_CMD     = 8'(BASE) + c_REG_CMD;
    localparam logic [7:0] c_ADDR_TIME_HI = 8'(BASE) + c_REG_TIME_HI;
    localparam logic [7:0] c_ADDR_TIME_LO = 8'(BASE) + c_REG_TIME_LO;
    localparam logic [7:0] c_ADDR_SID     = 8'(BASE) + c_REG_SID;
    localparam logic [7:0] c_ADDR_SPP     = 8'(BASE) + c_REG_SPP;

    logic w_rst;
    assign w_rst = reset | clear;

    logic [31:0] r_cmd_word, r_time_hi, r_sid;
    logic [15:0] r_spp;
    logic        r_act_imm, r_act_chain, r_act_reload;
    logic [27:0] r_act_num, r_samps_left;
    logic [63:0] r_act_time, r_pkt_time;
    logic [15:0] r_pkt_cnt;
    logic [31:0] r_sample0;
    logic [11:0] r_seqnum;
    logic [c_TDATA_W-1:0] r_tdata;
    logic        r_tvalid, r_err_stb;
    logic [63:0] r_err_code;
    rx_state_t   r_state, w_state_n;

    logic                w_commit, w_slot_full;
    logic [c_SLOT_W-1:0] w_slot_entry;
    logic [31:0]         w_slot_cmd;
    logic [63:0]         w_slot_time;
    logic                w_now, w_early, w_late;

    assign w_commit    = set_stb && (set_addr == c_ADDR_TIME_LO);
    assign w_slot_cmd  = w_slot_entry[95:64];
    assign w_slot_time = w_slot_entry[63:0];

    logic w_slot_load, w_slot_clr, w_start, w_arm, w_cap, w_emit, w_odd, w_eop, w_eob;
    logic w_chain_load, w_rearm, w_err;
    logic [31:0] w_err_word;

    rx_cmd_slot u_slot (
        .clk      (clk),
        .reset    (w_rst),
        .i_commit (w_commit),
        .i_entry  ({r_cmd_word, r_time_hi, set_data}),
        .i_load   (w_slot_load),
        .i_clr    (w_slot_clr),
        .o_full   (w_slot_full),
        .o_entry  (w_slot_entry)
    );

    time_compare u_tc (
        .i_time_now     (vita_time),
        .i_trigger_time (r_act_time),
        .o_now          (w_now),
        .o_early        (w_early),
        .o_late         (w_late)
    );

    logic [15:0] w_spp_eff;
    logic        w_last, w_pkt_full, w_stop, w_accept, w_accept_eop, w_out_busy;
    logic [11:0] w_seq_cur;

    assign w_spp_eff    = (r_spp == 16'd0) ? 16'd1 : r_spp;
    assign w_last       = (r_samps_left <= 28'd1);
    assign w_pkt_full   = (({1'b0, r_pkt_cnt} + 17'd1) >= {1'b0, w_spp_eff});
    assign w_stop       = w_slot_full && w_slot_cmd[28];
    assign w_accept     = r_tvalid && sample_tready;
    assign w_accept_eop = w_accept && r_tdata[c_BIT_EOP];
    // Output register counts as free if its line leaves this very cycle
    assign w_out_busy   = r_tvalid && !sample_tready;
    // Seqnum as it will be after any eop line accepted this cycle
    assign w_seq_cur    = r_seqnum + {11'd0, w_accept_eop};

    always_ff @(posedge clk) begin
        if (w_rst) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n    = r_state;
        w_slot_load  = 1'b0;
        w_slot_clr   = 1'b0;
        w_start      = 1'b0;
        w_arm        = 1'b0;
        w_cap        = 1'b0;
        w_emit       = 1'b0;
        w_odd        = 1'b0;
        w_eop        = 1'b0;
        w_eob        = 1'b0;
        w_chain_load = 1'b0;
        w_rearm      = 1'b0;
        w_err        = 1'b0;
        w_err_word   = 32'd0;
        unique case (r_state)
            S_IDLE: begin
                if (w_slot_full) begin
                    w_slot_load = 1'b1;
                    if (!w_slot_cmd[28]) begin
                        w_start   = 1'b1;
                        w_state_n = S_WAIT_TIME;
                    end
                end
            end
            S_WAIT_TIME: begin
                if (r_act_imm || w_now) begin
                    w_arm     = 1'b1;
                    w_state_n = S_SAMP0;
                end else if (w_late && !w_early) begin
                    w_err      = 1'b1;
                    w_err_word = c_ERR_LATE;
                    w_state_n  = S_ERROR;
                end
            end
            S_SAMP0: begin
                if (strobe) begin
                    if (w_out_busy) begin
                        w_err      = 1'b1;
                        w_err_word = c_ERR_OVERRUN;
                        w_slot_clr = 1'b1;
                        w_state_n  = S_ERROR;
                    end else begin
                        w_cap = 1'b1;
                        if (w_last || w_pkt_full || w_stop) begin
                            w_emit = 1'b1;
                            w_odd  = 1'b1;
                        end else begin
                            w_state_n = S_SAMP1;
                        end
                    end
                end
            end
            S_SAMP1: begin
                if (strobe) begin
                    w_cap     = 1'b1;
                    w_emit    = 1'b1;
                    w_state_n = S_SAMP0;
                end
            end
            S_ERROR: begin
                if (!r_tvalid) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
        // End-of-command handling shared by both capture states
        if (w_emit) begin
            w_eop = w_last || w_pkt_full || w_stop;
            if (w_stop) begin
                w_eob       = 1'b1;
                w_slot_load = 1'b1;
                w_state_n   = S_IDLE;
            end else if (w_last) begin
                if (!r_act_chain) begin
                    w_eob     = 1'b1;
                    w_state_n = S_IDLE;
                end else if (w_slot_full) begin
                    w_chain_load = 1'b1;
                    w_slot_load  = 1'b1;
                end else if (r_act_reload) begin
                    w_rearm = 1'b1;
                end else begin
                    w_eob      = 1'b1;
                    w_err      = 1'b1;
                    w_err_word = c_ERR_BROKEN_CHAIN;
                    w_state_n  = S_ERROR;
                end
            end
        end
    end

    logic [c_TDATA_W-1:0] w_line;
    logic [63:0]          w_time_first;

    assign w_time_first = (r_pkt_cnt == 16'd0) ? vita_time : r_pkt_time;

    always_comb begin
        w_line = '0;
        w_line[c_OFF_SAMPLE1 +: 32] = w_odd ? 32'd0 : sample;
        w_line[c_OFF_SAMPLE0 +: 32] = w_odd ? sample : r_sample0;
        w_line[c_OFF_TIME    +: 64] = w_time_first;
        w_line[c_OFF_SID     +: 32] = r_sid;
        w_line[c_OFF_SEQ     +: 12] = w_seq_cur;
        w_line[c_BIT_EOP]           = w_eop;
        w_line[c_BIT_EOB]           = w_eob;
        w_line[c_BIT_HAS_TIME]      = 1'b1;
        w_line[c_BIT_ODD]           = w_odd;
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_cmd_word   <= '0;
            r_time_hi    <= '0;
            r_sid        <= '0;
            r_spp        <= '0;
            r_act_imm    <= 1'b0;
            r_act_chain  <= 1'b0;
            r_act_reload <= 1'b0;
            r_act_num    <= '0;
            r_act_time   <= '0;
            r_samps_left <= '0;
            r_pkt_cnt    <= '0;
            r_pkt_time   <= '0;
            r_sample0    <= '0;
            r_seqnum     <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_err_stb    <= 1'b0;
            r_err_code   <= '0;
        end else begin
            if (set_stb && set_addr == c_ADDR_CMD)     r_cmd_word <= set_data;
            if (set_stb && set_addr == c_ADDR_TIME_HI) r_time_hi  <= set_data;
            if (set_stb && set_addr == c_ADDR_SID)     r_sid      <= set_data;
            if (set_stb && set_addr == c_ADDR_SPP)     r_spp      <= set_data[15:0];

            if (w_start) begin
                r_act_imm    <= w_slot_cmd[31];
                r_act_chain  <= w_slot_cmd[30];
                r_act_reload <= w_slot_cmd[29];
                r_act_num    <= w_slot_cmd[27:0];
                r_act_time   <= w_slot_time;
            end
            if (w_arm) begin
                r_samps_left <= r_act_num;
                r_pkt_cnt    <= '0;
            end
            if (w_cap) begin
                r_samps_left <= r_samps_left - 28'd1;
                if (r_state == S_SAMP0)  r_sample0  <= sample;
                if (r_pkt_cnt == 16'd0)  r_pkt_time <= vita_time;
                r_pkt_cnt <= (w_emit && w_eop) ? 16'd0 : r_pkt_cnt + 16'd1;
            end
            // A chained or re-armed command continues without a new time wait
            if (w_chain_load) begin
                r_act_imm    <= w_slot_cmd[31];
                r_act_chain  <= w_slot_cmd[30];
                r_act_reload <= w_slot_cmd[29];
                r_act_num    <= w_slot_cmd[27:0];
                r_act_time   <= w_slot_time;
                r_samps_left <= w_slot_cmd[27:0];
            end
            if (w_rearm) r_samps_left <= r_act_num;

            if (w_emit) begin
                r_tdata  <= w_line;
                r_tvalid <= 1'b1;
            end else if (w_accept) begin
                r_tvalid <= 1'b0;
            end

            if (set_stb && set_addr == c_ADDR_SID) r_seqnum <= '0;
            else if (w_accept_eop)                 r_seqnum <= r_seqnum + 12'd1;

            r_err_stb <= w_err;
            if (w_err) r_err_code <= f_err_code(w_err_word, w_seq_cur);
        end
    end

    assign run           = (r_state == S_SAMP0) || (r_state == S_SAMP1);
    assign busy          = (r_state == S_WAIT_TIME) || run || w_slot_full;
    assign sample_tdata  = r_tdata;
    assign sample_tvalid = r_tvalid;
    assign error_stb     = r_err_stb;
    assign error_code    = r_err_code;

`ifdef NEW_RX_CONTROL_STATS_EN
    logic [31:0] r_pkt_count, r_ovf_count;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_pkt_count <= '0;
            r_ovf_count <= '0;
        end else begin
            if (w_accept_eop && r_pkt_count != 32'hFFFF_FFFF)
                r_pkt_count <= r_pkt_count + 32'd1;
            if (w_err && w_err_word == c_ERR_OVERRUN && r_ovf_count != 32'hFFFF_FFFF)
                r_ovf_count <= r_ovf_count + 32'd1;
        end
    end

    assign pkt_count = r_pkt_count;
    assign ovf_count = r_ovf_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_new_rx_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_new_rx_control                                                          |
// | Directed self-checking bench for new_rx_control.                           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_new_rx_control;
    logic         clk = 1'b0;
    logic         reset, clear, set_stb, strobe, sample_tready;
    logic [7:0]   set_addr;
    logic [31:0]  set_data, sample;
    logic [63:0]  vita_time;
    logic         run, sample_tvalid, error_stb, busy;
    logic [175:0] sample_tdata;
    logic [63:0]  error_code;
`ifdef NEW_RX_CONTROL_STATS_EN
    logic [31:0]  pkt_count, ovf_count;
`endif

    always #5 clk = ~clk;

    new_rx_control #(.BASE(0)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .set_stb       (set_stb),
        .set_addr      (set_addr),
        .set_data      (set_data),
        .vita_time     (vita_time),
        .sample        (sample),
        .strobe        (strobe),
        .run           (run),
        .sample_tdata  (sample_tdata),
        .sample_tvalid (sample_tvalid),
        .sample_tready (sample_tready),
        .error_stb     (error_stb),
        .error_code    (error_code),
        .busy          (busy)
`ifdef NEW_RX_CONTROL_STATS_EN
       ,.pkt_count     (pkt_count),
        .ovf_count     (ovf_count)
`endif
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_err   = 0;
    logic [175:0] lines[$];
    logic [31:0]  exp_sid = 32'd0;

    // Transfers complete at the next rising edge; inputs only change just after rising edges
    always @(negedge clk) begin
        if (sample_tvalid && sample_tready) lines.push_back(sample_tdata);
        if (error_stb) n_err++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        step();
        set_stb = 1'b0;
    endtask

    task automatic commit(input logic [31:0] cmd, input logic [63:0] t);
        wr(8'd0, cmd);
        wr(8'd1, t[63:32]);
        wr(8'd2, t[31:0]);
    endtask

    task automatic samp(input logic [31:0] d, input logic [63:0] t);
        sample = d; vita_time = t; strobe = 1'b1;
        step();
        strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        lines.delete();
        n_err = 0;
        exp_sid = 32'd0;
    endtask

    task automatic wait_run(input string tag);
        for (int k = 0; k < 40 && !run; k++) step();
        check({tag, "_run_timeout"}, {63'd0, run}, 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40 && (busy || sample_tvalid || run); k++) step();
        step(2);
        check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_line(input string tag, input int idx, input logic [31:0] s0,
                              input logic [31:0] s1, input logic [63:0] t, input logic [11:0] seq,
                              input logic eop, input logic eob, input logic odd);
        logic [175:0] ln;
        if (lines.size() <= idx) begin
            check($sformatf("%s_line%0d_present", tag, idx), 64'(lines.size()), 64'(idx + 1));
            return;
        end
        ln = lines[idx];
        check($sformatf("%s_line%0d_s0", tag, idx), {32'd0, ln[63:32]}, {32'd0, s0});
        check($sformatf("%s_line%0d_s1", tag, idx), {32'd0, ln[31:0]}, {32'd0, s1});
        check($sformatf("%s_line%0d_time", tag, idx), ln[127:64], t);
        check($sformatf("%s_line%0d_sid", tag, idx), {32'd0, ln[159:128]}, {32'd0, exp_sid});
        check($sformatf("%s_line%0d_seq", tag, idx), {52'd0, ln[171:160]}, {52'd0, seq});
        check($sformatf("%s_line%0d_flags(odd,ht,eob,eop)", tag, idx), {60'd0, ln[175:172]},
              {60'd0, odd, 1'b1, eob, eop});
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        vita_time = '0; sample = '0; strobe = 1'b0; sample_tready = 1'b1;
        step(3);
        do_reset();

        // Reset state
        check("rst_tvalid", {63'd0, sample_tvalid}, 64'd0);
        check("rst_tdata_nz", {63'd0, |sample_tdata}, 64'd0);
        check("rst_error_stb", {63'd0, error_stb}, 64'd0);
        check("rst_error_code", error_code, 64'd0);
        check("rst_run", {63'd0, run}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);

        // Immediate command, spp=4, 8 samples back to back
        wr(8'd4, 32'd4);
        wr(8'd3, 32'h5151_0001);
        exp_sid = 32'h5151_0001;
        commit({4'b1000, 28'd8}, 64'd0);
        wait_run("imm");
        for (int i = 1; i <= 8; i++) samp(32'(i), 64'(100 + i));
        wait_idle("imm");
        check("imm_nlines", 64'(lines.size()), 64'd4);
        check("imm_nerr", 64'(n_err), 64'd0);
        check_line("imm", 0, 32'd1, 32'd2, 64'd101, 12'd0, 1'b0, 1'b0, 1'b0);
        check_line("imm", 1, 32'd3, 32'd4, 64'd101, 12'd0, 1'b1, 1'b0, 1'b0);
        check_line("imm", 2, 32'd5, 32'd6, 64'd105, 12'd1, 1'b0, 1'b0, 1'b0);
        check_line("imm", 3, 32'd7, 32'd8, 64'd105, 12'd1, 1'b1, 1'b1, 1'b0);

        // Timed command: waits until vita_time reaches 1000, 3 samples -> odd final line
        do_reset();
        wr(8'd4, 32'd4);
        vita_time = 64'd900;
        commit({4'b0000, 28'd3}, 64'd1000);
        step(5);
        check("timed_wait_run", {63'd0, run}, 64'd0);
        check("timed_wait_busy", {63'd0, busy}, 64'd1);
        vita_time = 64'd1000;
        wait_run("timed");
        samp(32'hA1, 64'd1000);
        samp(32'hA2, 64'd1001);
        samp(32'hA3, 64'd1002);
        wait_idle("timed");
        check("timed_nlines", 64'(lines.size()), 64'd2);
        check_line("timed", 0, 32'hA1, 32'hA2, 64'd1000, 12'd0, 1'b0, 1'b0, 1'b0);
        check_line("timed", 1, 32'hA3, 32'h0, 64'd1000, 12'd0, 1'b1, 1'b1, 1'b1);

        // Late command
        do_reset();
        vita_time = 64'd600;
        commit({4'b0000, 28'd4}, 64'd500);
        step(6);
        check("late_pulses", 64'(n_err), 64'd1);
        check("late_code", error_code, 64'h0000_0002_0000_0000);
        check("late_nlines", 64'(lines.size()), 64'd0);
        check("late_busy", {63'd0, busy}, 64'd0);

        // Broken chain
        do_reset();
        wr(8'd4, 32'd4);
        commit({4'b1100, 28'd4}, 64'd0);
        wait_run("brk");
        for (int i = 1; i <= 4; i++) samp(32'(16 + i), 64'(300 + i));
        wait_idle("brk");
        check("brk_nlines", 64'(lines.size()), 64'd2);
        check_line("brk", 1, 32'd19, 32'd20, 64'd301, 12'd0, 1'b1, 1'b1, 1'b0);
        check("brk_pulses", 64'(n_err), 64'd1);
        check("brk_code", error_code, 64'h0000_0004_0000_0000);
        check("brk_run", {63'd0, run}, 64'd0);

        // Overrun with framer stalled
        do_reset();
        wr(8'd4, 32'd4);
        sample_tready = 1'b0;
        commit({4'b1000, 28'd16}, 64'd0);
        wait_run("ovr");
        samp(32'd1, 64'd10);
        samp(32'd2, 64'd11);
        samp(32'd3, 64'd12);
        step(3);
        check("ovr_pulses", 64'(n_err), 64'd1);
        check("ovr_code", error_code, 64'h0000_0008_0000_0000);
        check("ovr_queued_tvalid", {63'd0, sample_tvalid}, 64'd1);
        check("ovr_run", {63'd0, run}, 64'd0);
        sample_tready = 1'b1;
        wait_idle("ovr");
        check("ovr_nlines", 64'(lines.size()), 64'd1);
        check_line("ovr", 0, 32'd1, 32'd2, 64'd10, 12'd0, 1'b0, 1'b0, 1'b0);
        commit({4'b1000, 28'd2}, 64'd0);
        wait_run("ovr2");
        samp(32'h55, 64'd20);
        samp(32'h66, 64'd21);
        wait_idle("ovr2");
        check_line("ovr2", 1, 32'h55, 32'h66, 64'd20, 12'd0, 1'b1, 1'b1, 1'b0);

        // Seamless chain into a second command
        do_reset();
        wr(8'd4, 32'd4);
        commit({4'b1100, 28'd4}, 64'd0);
        wait_run("chn");
        commit({4'b1000, 28'd4}, 64'd0);
        for (int i = 1; i <= 8; i++) samp(32'(32 + i), 64'(200 + i));
        wait_idle("chn");
        check("chn_nlines", 64'(lines.size()), 64'd4);
        check("chn_nerr", 64'(n_err), 64'd0);
        check_line("chn", 0, 32'd33, 32'd34, 64'd201, 12'd0, 1'b0, 1'b0, 1'b0);
        check_line("chn", 1, 32'd35, 32'd36, 64'd201, 12'd0, 1'b1, 1'b0, 1'b0);
        check_line("chn", 2, 32'd37, 32'd38, 64'd205, 12'd1, 1'b0, 1'b0, 1'b0);
        check_line("chn", 3, 32'd39, 32'd40, 64'd205, 12'd1, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
